// File: rtl/fetch_prefetch_pkg.sv
// Shared types for the prefetching instruction-fetch stage.
// Holds the EX redirect bundle, the IF/ID bundle and the fetch-queue entry.
// Also provides the word-alignment helper used on redirect targets.
package fetch_prefetch_pkg;

  localparam int XLEN  = 32;
  localparam int DATAW = 32;
  localparam int ADDRW = XLEN;

  typedef struct packed {
    logic            jump_en;
    logic [XLEN-1:0] jump_addr;
  } ex_if_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [DATAW-1:0] instr;
    logic             valid;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [DATAW-1:0] instr;
  } fetch_entry_t;

  // Redirect targets may carry junk in the low bits; fetch is word granular.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Purpose: generic registered FIFO (module fetch_fifo) with synchronous flush.
// Latency: push visible at head_o the cycle after the push edge (no bypass).
// Backpressure: push ignored when full unless a pop frees a slot the same cycle; flush beats push and pop.
// Ports: clk_i/rst_i (async active-high), push_i/data_i, pop_i, flush_i,
//        full_o/empty_o/count_o status, head_o oldest entry.
module fetch_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output T                           head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read past the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Purpose: pipelined instruction fetch, up to MAX_OUTSTANDING in-order I$ requests feeding a FETCH_DEPTH queue.
// Latency: I$ response to if_id_o.valid is 1 cycle (registered queue).
// Backpressure: stall_i holds the queue head; issue is credit-limited so every response has a free slot.
// Ports: clk_i/rst_i (async active-high); imem_addr_o/imem_valid_o/imem_ready_i request side;
//        imem_resp_i/imem_rdata_i response side; stall_i from decode; ex_if_i redirect; if_id_o to decode.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET_ADDR   = 32'h8000_0000,
  parameter int              FETCH_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [ADDRW-1:0] imem_addr_o,
  output logic             imem_valid_o,
  input  logic             imem_ready_i,
  input  logic             imem_resp_i,
  input  logic [DATAW-1:0] imem_rdata_i,
  input  logic             stall_i,
  input  ex_if_t           ex_if_i,
  output if_id_t           if_id_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FETCH_DEPTH + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  logic [OW-1:0]   outst_q,    outst_d;
  logic [OW-1:0]   discard_q,  discard_d;

  logic            jump;
  logic            issue;
  logic            push;
  logic            pop;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  logic [SW-1:0]   credit_sum;
  fetch_entry_t    q_in, q_head;

  assign jump = ex_if_i.jump_en;

  // Queued entries plus words still in flight must fit the queue; that is the credit.
  assign credit_sum = SW'(q_count) + SW'(outst_q);

  // rst_i gating keeps the request quiet while reset holds the counters at zero.
  // q_full is implied by the credit check and only guards against a misparameterised queue.
  assign imem_valid_o = !rst_i && !jump && !q_full
                        && (outst_q < OW'(MAX_OUTSTANDING))
                        && (credit_sum < SW'(FETCH_DEPTH));
  assign imem_addr_o  = fetch_pc_q;
  assign issue        = imem_valid_o && imem_ready_i;

  // A response in a redirect cycle is wrong-path and joins the dropped words.
  assign push = imem_resp_i && !jump && (discard_q == '0);
  assign pop  = if_id_o.valid && !stall_i;

  assign q_in.pc    = resp_pc_q;
  assign q_in.instr = imem_rdata_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + OW'(issue) - OW'(imem_resp_i);
    discard_d  = discard_q;
    if (jump) begin
      fetch_pc_d = word_align(ex_if_i.jump_addr);
      resp_pc_d  = word_align(ex_if_i.jump_addr);
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d  = outst_q - OW'(imem_resp_i);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end else if (imem_resp_i) begin
        discard_d = discard_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q <= PC_RESET_ADDR;
      resp_pc_q  <= PC_RESET_ADDR;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FETCH_DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (q_in),
    .pop_i   (pop),
    .flush_i (jump),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count),
    .head_o  (q_head)
  );

  always_comb begin
    if_id_o.pc    = q_head.pc;
    if_id_o.instr = q_head.instr;
    if_id_o.valid = !q_empty && !jump;
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_o;
  logic        imem_valid_o;
  logic        imem_ready_i;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  ex_if_t      ex_if_i;
  if_id_t      if_id_o;

  fetch_prefetch #(
    .PC_RESET_ADDR   (RST_PC),
    .FETCH_DEPTH     (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_addr_o  (imem_addr_o),
    .imem_valid_o (imem_valid_o),
    .imem_ready_i (imem_ready_i),
    .imem_resp_i  (imem_resp_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .ex_if_i      (ex_if_i),
    .if_id_o      (if_id_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: I$ in-flight list and the words decode should see, in order.
  logic [31:0] pend_addr[$];
  logic [31:0] pend_mpc[$];
  int          pend_due[$];
  int          pend_ep[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];
  logic [31:0] next_fetch = RST_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  logic [31:0] last_pop_pc = '0;

  int rdy_pct = 100, stall_pct = 0, jmp_pct = 0, lat_min = 1, lat_max = 1;
  bit rel_pending = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[17:2]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares decode-side behaviour against the model every cycle.
  logic        exp_vld, exp_ivld;
  logic [31:0] e_pc, e_in;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_resp_i && pend_addr.size() == 0))
        else $error("I$ response with nothing outstanding");
      exp_vld  = (exp_pc_q.size() != 0) && !ex_if_i.jump_en;
      chk("if_id_valid", {31'b0, if_id_o.valid}, {31'b0, exp_vld});
      exp_ivld = !ex_if_i.jump_en && (pend_addr.size() < MAX_OUT)
                 && (exp_pc_q.size() + pend_addr.size() < DEPTH);
      chk("imem_valid", {31'b0, imem_valid_o}, {31'b0, exp_ivld});
      if (if_id_o.valid && !stall_i) begin
        if (exp_pc_q.size() == 0) begin
          chk("pop_unexpected", {31'b0, if_id_o.valid}, 32'd0);
        end else begin
          e_pc = exp_pc_q.pop_front();
          e_in = exp_ins_q.pop_front();
          chk("pop_pc", if_id_o.pc, e_pc);
          chk("pop_instr", if_id_o.instr, e_in);
          last_pop_pc = if_id_o.pc;
          pop_cnt++;
        end
      end
    end
  end

  // One clock of stimulus; the bookkeeping records what the next edge will do.
  task automatic step(input bit force_jump, input logic [31:0] tgt);
    logic [31:0] a, mpc;
    int          ep;
    @(posedge clk_i);
    cyc++;
    #1;
    if (rel_pending) begin
      rst_i       = 1'b0;
      rel_pending = 0;
    end
    imem_ready_i      = ($urandom_range(0, 99) < rdy_pct);
    stall_i           = ($urandom_range(0, 99) < stall_pct);
    imem_resp_i       = !rst_i && (pend_addr.size() != 0) && (pend_due[0] <= cyc);
    imem_rdata_i      = imem_resp_i ? mem_word(pend_addr[0]) : 32'h0;
    ex_if_i.jump_en   = force_jump || ($urandom_range(0, 99) < jmp_pct);
    ex_if_i.jump_addr = force_jump ? tgt : RST_PC + 32'($urandom_range(0, 4095));
    @(negedge clk_i);
    #1;
    if (!rst_i) begin
      if (imem_valid_o && imem_ready_i) begin
        chk("req_addr", imem_addr_o, next_fetch);
        pend_addr.push_back(imem_addr_o);
        pend_mpc.push_back(next_fetch);
        pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        pend_ep.push_back(epoch);
        next_fetch += 32'd4;
      end
      if (imem_resp_i) begin
        a   = pend_addr.pop_front();
        mpc = pend_mpc.pop_front();
        ep  = pend_ep.pop_front();
        void'(pend_due.pop_front());
        if (!ex_if_i.jump_en && ep == epoch) begin
          exp_pc_q.push_back(mpc);
          exp_ins_q.push_back(mem_word(mpc));
        end
      end
      if (ex_if_i.jump_en) begin
        epoch++;
        next_fetch = {ex_if_i.jump_addr[31:2], 2'b00};
        exp_pc_q.delete();
        exp_ins_q.delete();
      end
    end
  endtask

  task automatic wait_pop(input string nm, input logic [31:0] want);
    int p0 = pop_cnt;
    for (int i = 0; i < 40 && pop_cnt == p0; i++) step(1'b0, 32'h0);
    if (pop_cnt == p0) chk({nm, "_timeout"}, {31'b0, if_id_o.valid}, 32'd2);
    else chk(nm, last_pop_pc, want);
  endtask

  initial begin
    int  p0;
    bit  done;
    rst_i = 1'b1;
    imem_ready_i = 1'b0;
    imem_resp_i = 1'b0;
    imem_rdata_i = '0;
    stall_i = 1'b0;
    ex_if_i = '0;
    #2;
    chk("rst_imem_valid", {31'b0, imem_valid_o}, 32'd0);
    chk("rst_if_id_valid", {31'b0, if_id_o.valid}, 32'd0);
    chk("rst_addr", imem_addr_o, RST_PC);
    repeat (2) step(1'b0, 32'h0);
    rel_pending = 1;

    // Streaming with a 1-cycle I$: one instruction per cycle once warm.
    repeat (10) step(1'b0, 32'h0);
    p0 = pop_cnt;
    repeat (20) step(1'b0, 32'h0);
    chk("stream_rate", 32'(pop_cnt - p0), 32'd20);

    // Decode stall fills the queue and starves issue; release drains in order.
    stall_pct = 100;
    repeat (10) step(1'b0, 32'h0);
    chk("stall_imem_valid", {31'b0, imem_valid_o}, 32'd0);
    chk("stall_if_id_valid", {31'b0, if_id_o.valid}, 32'd1);
    stall_pct = 0;
    p0 = pop_cnt;
    repeat (4) step(1'b0, 32'h0);
    chk("stall_drain", 32'(pop_cnt - p0), 32'd4);

    // Redirect coinciding with a response and a pop: queue empty next cycle.
    repeat (5) step(1'b0, 32'h0);
    step(1'b1, 32'h8000_0080);
    step(1'b0, 32'h0);
    chk("redir_resp_empty", {31'b0, if_id_o.valid}, 32'd0);
    wait_pop("redir_resp_first", 32'h8000_0080);

    // Redirect with two requests in flight and no response that cycle.
    lat_min = 4;
    lat_max = 4;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (pend_addr.size() == 2 && !(pend_due[0] <= cyc + 1)) begin
        step(1'b1, 32'h8000_0100);
        done = 1;
      end else begin
        step(1'b0, 32'h0);
      end
    end
    if (!done) chk("two_inflight_timeout", {31'b0, imem_valid_o}, 32'd2);
    wait_pop("two_inflight_first", 32'h8000_0100);
    lat_min = 1;
    lat_max = 1;

    // Unaligned target, then back-to-back redirects.
    step(1'b1, 32'h8000_0203);
    step(1'b0, 32'h0);
    chk("align_addr", imem_addr_o, 32'h8000_0200);
    wait_pop("align_first", 32'h8000_0200);
    step(1'b1, 32'h8000_0300);
    step(1'b1, 32'h8000_0350);
    step(1'b1, 32'h8000_0403);
    wait_pop("b2b_last_wins", 32'h8000_0400);

    // Randomised traffic against the model.
    rdy_pct = 75;
    stall_pct = 30;
    jmp_pct = 4;
    lat_min = 1;
    lat_max = 4;
    repeat (1500) step(1'b0, 32'h0);

    // Asynchronous reset in mid-stream.
    rdy_pct = 100;
    stall_pct = 0;
    jmp_pct = 0;
    lat_min = 1;
    lat_max = 1;
    repeat (12) step(1'b0, 32'h0);
    @(posedge clk_i);
    #2;
    chk("pre_rst_imem_valid", {31'b0, imem_valid_o}, 32'd1);
    chk("pre_rst_if_id_valid", {31'b0, if_id_o.valid}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_imem_valid", {31'b0, imem_valid_o}, 32'd0);
    chk("async_rst_if_id_valid", {31'b0, if_id_o.valid}, 32'd0);
    chk("async_rst_addr", imem_addr_o, RST_PC);
    pend_addr.delete();
    pend_mpc.delete();
    pend_due.delete();
    pend_ep.delete();
    exp_pc_q.delete();
    exp_ins_q.delete();
    next_fetch = RST_PC;
    epoch++;
    imem_resp_i = 1'b0;
    repeat (2) step(1'b0, 32'h0);
    rel_pending = 1;
    wait_pop("restart_first", RST_PC);
    repeat (20) step(1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
